// File: rtl/sc_down_counter_pkg.sv
// rtl/sc_down_counter_pkg.sv - shared state encoding for the SC down-counter/timer
package sc_down_counter_pkg;

  localparam int STATE_WIDTH = 2;

  localparam logic [STATE_WIDTH-1:0] STATE_IDLE    = 2'd0;
  localparam logic [STATE_WIDTH-1:0] STATE_RUN     = 2'd1;
  localparam logic [STATE_WIDTH-1:0] STATE_EXPIRED = 2'd2;

  // Next state after a load: a nonzero start value runs, a zero start value is already expired
  function automatic logic [STATE_WIDTH-1:0] loadState(input logic loadIsZero);
    return loadIsZero ? STATE_EXPIRED : STATE_RUN;
  endfunction

endpackage

// File: rtl/sc_down_counter_timer.sv
// rtl/sc_down_counter_timer.sv - loadable down-counter/timer with one-shot and auto-reload modes
module sc_down_counter_timer
  import sc_down_counter_pkg::*;
#(
  parameter int downCOUNTER_DATAWIDTH = 8
) (
  input  logic                             SC_downCOUNTER_CLOCK_50,
  input  logic                             SC_downCOUNTER_RESET_InHigh,
  input  logic                             SC_downCOUNTER_load_InLow,
  input  logic [downCOUNTER_DATAWIDTH-1:0] SC_downCOUNTER_data_InBUS,
  input  logic                             SC_downCOUNTER_downcount_InLow,
  input  logic                             SC_downCOUNTER_autoreload_InHigh,
  output logic [downCOUNTER_DATAWIDTH-1:0] SC_downCOUNTER_data_OutBUS,
  output logic                             SC_downCOUNTER_zero_OutHigh,
  output logic                             SC_downCOUNTER_tc_OutHigh,
  output logic                             SC_downCOUNTER_busy_OutHigh
);

  localparam logic [downCOUNTER_DATAWIDTH-1:0] countZero = '0;
  localparam logic [downCOUNTER_DATAWIDTH-1:0] countOne  = {{(downCOUNTER_DATAWIDTH-1){1'b0}}, 1'b1};

  logic [STATE_WIDTH-1:0]           stateReg;
  logic [STATE_WIDTH-1:0]           stateNext;
  logic [downCOUNTER_DATAWIDTH-1:0] countReg;
  logic [downCOUNTER_DATAWIDTH-1:0] countNext;
  logic [downCOUNTER_DATAWIDTH-1:0] reloadReg;
  logic [downCOUNTER_DATAWIDTH-1:0] reloadNext;
  logic                             tcReg;
  logic                             tcNext;

  // Register state, count, reload value and terminal-count pulse; reset wins over everything
  always_ff @(posedge SC_downCOUNTER_CLOCK_50) begin
    if (SC_downCOUNTER_RESET_InHigh) begin
      stateReg  <= STATE_IDLE;
      countReg  <= countZero;
      reloadReg <= countZero;
      tcReg     <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      countReg  <= countNext;
      reloadReg <= reloadNext;
      tcReg     <= tcNext;
    end
  end

  // Next state/count: load beats decrement beats hold; tc only fires on the count==1 decrement
  always_comb begin
    stateNext  = stateReg;
    countNext  = countReg;
    reloadNext = reloadReg;
    tcNext     = 1'b0;
    if (!SC_downCOUNTER_load_InLow) begin
      countNext  = SC_downCOUNTER_data_InBUS;
      reloadNext = SC_downCOUNTER_data_InBUS;
      stateNext  = loadState(SC_downCOUNTER_data_InBUS == countZero);
    end else begin
      case (stateReg)
        STATE_RUN: begin
          if (!SC_downCOUNTER_downcount_InLow) begin
            if (countReg > countOne) begin
              countNext = countReg - countOne;
            end else if (countReg == countOne) begin
              tcNext = 1'b1;
              if (SC_downCOUNTER_autoreload_InHigh) begin
                countNext = reloadReg;
              end else begin
                countNext = countZero;
                stateNext = STATE_EXPIRED;
              end
            end else begin
              // RUN with a zero count is not reachable; settle into EXPIRED rather than wrap
              countNext = countZero;
              stateNext = STATE_EXPIRED;
            end
          end
        end
        STATE_IDLE, STATE_EXPIRED: begin
          countNext = countZero;
        end
        default: begin
          stateNext = STATE_IDLE;
          countNext = countZero;
        end
      endcase
    end
  end

  // Output decode, purely from registers
  always_comb begin
    SC_downCOUNTER_data_OutBUS  = countReg;
    SC_downCOUNTER_zero_OutHigh = (countReg == countZero);
    SC_downCOUNTER_busy_OutHigh = (stateReg == STATE_RUN);
    SC_downCOUNTER_tc_OutHigh   = tcReg;
  end

endmodule

// File: tb/tb_sc_down_counter_timer.sv
// tb/tb_sc_down_counter_timer.sv - scoreboard bench for sc_down_counter_timer
module tb_sc_down_counter_timer;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] count;
    logic         tc;
    logic         zero;
    logic         busy;
  } expT;

  logic         clk;
  logic         rst;
  logic         loadN;
  logic [W-1:0] dataIn;
  logic         downN;
  logic         autoReload;
  logic [W-1:0] dataOut;
  logic         zeroOut;
  logic         tcOut;
  logic         busyOut;

  expT expQ[$];
  int  checkCount;
  int  errorCount;
  bit  monitorOn;

  sc_down_counter_timer #(.downCOUNTER_DATAWIDTH(W)) dut (
    .SC_downCOUNTER_CLOCK_50          (clk),
    .SC_downCOUNTER_RESET_InHigh      (rst),
    .SC_downCOUNTER_load_InLow        (loadN),
    .SC_downCOUNTER_data_InBUS        (dataIn),
    .SC_downCOUNTER_downcount_InLow   (downN),
    .SC_downCOUNTER_autoreload_InHigh (autoReload),
    .SC_downCOUNTER_data_OutBUS       (dataOut),
    .SC_downCOUNTER_zero_OutHigh      (zeroOut),
    .SC_downCOUNTER_tc_OutHigh        (tcOut),
    .SC_downCOUNTER_busy_OutHigh      (busyOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the post-edge expectation
  task automatic step(input string tag, input logic r, input logic ld, input logic [W-1:0] d,
                      input logic dn, input logic ar,
                      input int eCount, input logic eTc, input logic eZero, input logic eBusy);
    expT e;
    @(negedge clk);
    rst        = r;
    loadN      = ld;
    dataIn     = d;
    downN      = dn;
    autoReload = ar;
    e.count = eCount[W-1:0];
    e.tc    = eTc;
    e.zero  = eZero;
    e.busy  = eBusy;
    expQ.push_back(e);
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest queued expectation
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (monitorOn && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkValue("count", int'(dataOut), int'(e.count));
        checkValue("tc",    int'(tcOut),   int'(e.tc));
        checkValue("zero",  int'(zeroOut), int'(e.zero));
        checkValue("busy",  int'(busyOut), int'(e.busy));
      end
    end
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    monitorOn  = 1'b1;
    rst = 1'b1; loadN = 1'b1; dataIn = '0; downN = 1'b1; autoReload = 1'b0;

    // 1: reset held two clocks, then enable pulses leave count at 0
    step("rst0", 1, 1, 8'd0, 1, 0, 0, 0, 1, 0);
    step("rst1", 1, 1, 8'd0, 1, 0, 0, 0, 1, 0);
    step("idle0", 0, 1, 8'd0, 0, 0, 0, 0, 1, 0);
    step("idle1", 0, 1, 8'd0, 0, 1, 0, 0, 1, 0);

    // 2: one-shot load 3 and count to expiry, no wrap afterwards
    step("ld3", 0, 0, 8'd3, 1, 0, 3, 0, 0, 1);
    step("os2", 0, 1, 8'd0, 0, 0, 2, 0, 0, 1);
    step("os1", 0, 1, 8'd0, 0, 0, 1, 0, 0, 1);
    step("os0", 0, 1, 8'd0, 0, 0, 0, 1, 1, 0);
    step("exp0", 0, 1, 8'd0, 0, 0, 0, 0, 1, 0);
    step("exp1", 0, 1, 8'd0, 0, 0, 0, 0, 1, 0);

    // 3: auto-reload with period 4
    step("ld4", 0, 0, 8'd4, 0, 1, 4, 0, 0, 1);
    step("ar3", 0, 1, 8'd0, 0, 1, 3, 0, 0, 1);
    step("ar2", 0, 1, 8'd0, 0, 1, 2, 0, 0, 1);
    step("ar1", 0, 1, 8'd0, 0, 1, 1, 0, 0, 1);
    step("ar4", 0, 1, 8'd0, 0, 1, 4, 1, 0, 1);
    step("ar3b", 0, 1, 8'd0, 0, 1, 3, 0, 0, 1);
    step("ar2b", 0, 1, 8'd0, 0, 1, 2, 0, 0, 1);
    step("ar1b", 0, 1, 8'd0, 0, 1, 1, 0, 0, 1);
    step("ar4b", 0, 1, 8'd0, 0, 1, 4, 1, 0, 1);
    // autoreload dropped mid-count is honoured at the count==1 edge; hold keeps the count
    step("hold", 0, 1, 8'd0, 1, 0, 4, 0, 0, 1);
    step("m3", 0, 1, 8'd0, 0, 0, 3, 0, 0, 1);
    step("m2", 0, 1, 8'd0, 0, 0, 2, 0, 0, 1);
    step("m1", 0, 1, 8'd0, 0, 0, 1, 0, 0, 1);
    step("m0", 0, 1, 8'd0, 0, 0, 0, 1, 1, 0);

    // 4: load wins over decrement mid-count
    step("ld5", 0, 0, 8'd5, 1, 0, 5, 0, 0, 1);
    step("d4", 0, 1, 8'd0, 0, 0, 4, 0, 0, 1);
    step("d3", 0, 1, 8'd0, 0, 0, 3, 0, 0, 1);
    step("ld9", 0, 0, 8'd9, 0, 0, 9, 0, 0, 1);

    // 5: reset mid-count while enabled returns to IDLE
    step("ld6", 0, 0, 8'd6, 1, 0, 6, 0, 0, 1);
    step("e5", 0, 1, 8'd0, 0, 0, 5, 0, 0, 1);
    step("e4", 0, 1, 8'd0, 0, 0, 4, 0, 0, 1);
    step("e3", 0, 1, 8'd0, 0, 0, 3, 0, 0, 1);
    step("e2", 0, 1, 8'd0, 0, 0, 2, 0, 0, 1);
    step("rstmid", 1, 1, 8'd0, 0, 0, 0, 0, 1, 0);
    step("idle2", 0, 1, 8'd0, 0, 0, 0, 0, 1, 0);

    // 6: load 0 gives no tc; load 1 expires in one enabled cycle
    step("ld0", 0, 0, 8'd0, 1, 0, 0, 0, 1, 0);
    step("z0", 0, 1, 8'd0, 0, 0, 0, 0, 1, 0);
    step("ld1", 0, 0, 8'd1, 1, 0, 1, 0, 0, 1);
    step("t0", 0, 1, 8'd0, 0, 0, 0, 1, 1, 0);
    step("t1", 0, 1, 8'd0, 0, 0, 0, 0, 1, 0);

    // reload of 1 with auto-reload: count stays 1, tc every enabled cycle
    step("ld1ar", 0, 0, 8'd1, 1, 1, 1, 0, 0, 1);
    step("r1a", 0, 1, 8'd0, 0, 1, 1, 1, 0, 1);
    step("r1b", 0, 1, 8'd0, 0, 1, 1, 1, 0, 1);
    step("r1h", 0, 1, 8'd0, 1, 1, 1, 0, 0, 1);

    // full-scale load counts down without issue
    step("ldff", 0, 0, 8'd255, 1, 0, 255, 0, 0, 1);
    step("dfe", 0, 1, 8'd0, 0, 0, 254, 0, 0, 1);

    @(negedge clk);
    downN = 1'b1;
    loadN = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkValue("drain", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
